div_result_buffer: RTL and testbench
====================================

// Module: div_result_buffer
// PURPOSE
// Downstream stage of the PE multicycle divider. Reserves result space before a division is issued.
// Captures the quotient or remainder on the divider's one-cycle valid pulse and queues it in a DEPTH-entry FIFO.
// Presents queued results to the PE output mux with a valid/ready handshake.
// issue_ready_o provides credit-based back-pressure, so a finished division can never be lost.
// PARAMETERS
// N_BITS  32  datapath width; matches divider q/r width
// DEPTH   4   result FIFO entries; power of two, >=2; also the max of (queued + in-flight) ops
// PORTS
// clk_i           in   1       clock, all state updates on rising edge
// rst_i           in   1       synchronous reset, active-high
// issue_valid_i   in   1       upstream wants to start a division this cycle
// issue_rem_i     in   1       op tag for the issued division: 0 = keep quotient, 1 = keep remainder
// issue_ready_o   out  1       a result slot is reserved if the issue handshake completes
// div_valid_i     in   1       divider finished; q/r valid this cycle only
// div_q_i         in   N_BITS  signed quotient from the divider
// div_r_i         in   N_BITS  signed remainder from the divider
// res_valid_o     out  1       FIFO head holds a result
// res_data_o      out  N_BITS  FIFO head data; meaningful only while res_valid_o = 1
// res_ready_i     in   1       consumer accepts the head this cycle
// count_o         out  $clog2(DEPTH+1)  number of entries currently queued
// err_o           out  1       sticky: div_valid_i seen with no op in flight
// BEHAVIOUR
// - Reset (rst_i = 1 at a clock edge) forces the following; any op in flight is forgotten.
//   - res_valid_o = 0, res_data_o = 0, count_o = 0, err_o = 0, issue_ready_o = 1.
//   - In-flight counter, tag FIFO and read/write pointers are cleared.
// - State:
//   - data FIFO: DEPTH x N_BITS.
//   - tag FIFO: DEPTH x 1, holds issue_rem_i in issue order.
//   - inflight counter: 0..DEPTH.
//   - all pointers wrap modulo DEPTH.
// - issue_ready_o = (count + inflight < DEPTH); combinational from registered state only, never from issue_valid_i.
// - Issue handshake: issue_valid_i & issue_ready_o at edge t.
//   - issue_rem_i is pushed to the tag FIFO.
//   - inflight increments.
//   - Visible at t+1.
// - Capture: div_valid_i & (inflight != 0) at edge t.
//   - The tag FIFO head is popped.
//   - Data = tag ? div_r_i : div_q_i is written to the data FIFO.
//   - inflight decrements and count increments.
//   - res_valid_o = 1 from t+1; result latency is 1 cycle.
// - Stray result: div_valid_i with inflight == 0.
//   - The data is dropped; the FIFOs and counters are unchanged.
//   - err_o is set and stays set until reset.
// - Drain: res_valid_o & res_ready_i at edge t pops the head; count decrements.
// - Simultaneous events within one cycle all apply; the net counter deltas are summed.
//   - Issue + capture: inflight is unchanged, count +1.
//   - Capture + drain: count is unchanged and the head advances.
//   - Issue + drain while count + inflight == DEPTH: the issue is NOT accepted. The credit freed by the drain is visible from the next cycle.
// - Overflow: by construction, count + inflight never exceeds DEPTH. An assertion checks this.
// - Empty: res_valid_o = 0. res_ready_i is ignored, and res_data_o holds its last value (no X).
// - Data is passed through bit-exact; no sign handling is done here, since the divider already applies it.
// - Capture, issue, drain and reset are all synchronous; no combinational path from div_valid_i to res_valid_o.
// TESTING
// - Reset, then idle -> issue_ready_o=1, res_valid_o=0, count_o=0, err_o=0.
// - Issue rem=0, then div_valid with q=32'hFFFF_FFFD, r=32'h1 -> res_data_o=32'hFFFF_FFFD one cycle later; pop -> count_o=0.
// - Issue 4 ops with tags 1,0,1,0 and res_ready_i=0 -> issue_ready_o=0 after the 4th. Four captures with q=10..13, r=20..23 -> drain order 20,11,22,13.
// - Full FIFO (count=4); same cycle drain + issue_valid -> issue not accepted. issue_ready_o=1 on the next cycle only.
// - div_valid_i pulse with no op issued -> err_o=1 and stays 1; count_o stays 0. rst_i -> err_o=0.
// - 2 ops in flight, rst_i asserted for 1 cycle, then a late div_valid_i -> result dropped, err_o=1, count_o=0.

Source files
------------

// File: rtl/div_result_buffer.sv
// Result buffer behind the multicycle divider: reserves a slot per issued op, captures q or r
// on the divider's done pulse, and hands results to the consumer through a valid/ready FIFO.
module div_result_buffer #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  input  logic                       issue_rem_i,
  output logic                       issue_ready_o,
  input  logic                       div_valid_i,
  input  logic [N_BITS-1:0]          div_q_i,
  input  logic [N_BITS-1:0]          div_r_i,
  output logic                       res_valid_o,
  output logic [N_BITS-1:0]          res_data_o,
  input  logic                       res_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [N_BITS-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  tag_reg;
  logic [DEPTH-1:0]  tag_we;

  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, tag_wr_ptr_reg, tag_rd_ptr_reg;
  logic [PW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [CW-1:0]     inflight_reg, inflight_next;
  logic              err_reg;
  logic [N_BITS-1:0] res_data_reg, res_data_next;

  logic              issue_fire, capture_fire, stray_fire, drain_fire;
  logic [N_BITS-1:0] cap_data;
  logic [CW:0]       occupancy;

  // Credit check uses registered state only, so issue_ready_o never depends on issue_valid_i.
  assign occupancy     = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign issue_ready_o = (occupancy < DEPTH_W);
  assign res_valid_o   = (count_reg != '0);
  assign res_data_o    = res_data_reg;
  assign count_o       = count_reg;
  assign err_o         = err_reg;

  assign issue_fire   = issue_valid_i & issue_ready_o;
  assign capture_fire = div_valid_i & (inflight_reg != '0);
  assign stray_fire   = div_valid_i & (inflight_reg == '0);
  assign drain_fire   = res_valid_o & res_ready_i;
  assign cap_data     = tag_reg[tag_rd_ptr_reg] ? div_r_i : div_q_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag_we
    assign tag_we[gi] = issue_fire && (tag_wr_ptr_reg == PW'(gi));
  end

  always_comb begin
    count_next    = count_reg + CW'(capture_fire) - CW'(drain_fire);
    inflight_next = inflight_reg + CW'(issue_fire) - CW'(capture_fire);
    rd_ptr_next   = rd_ptr_reg + PW'(drain_fire);
    res_data_next = res_data_reg;
    // Head register tracks the entry that will be at the front after this edge; the slot
    // being written this edge is forwarded since the array read would still be stale.
    if (count_next != '0) begin
      if (capture_fire && (wr_ptr_reg == rd_ptr_next)) begin
        res_data_next = cap_data;
      end else begin
        res_data_next = data_mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture_fire) begin
      data_mem[wr_ptr_reg] <= cap_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_we[i]) begin
          tag_reg[i] <= issue_rem_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      count_reg      <= '0;
      inflight_reg   <= '0;
      err_reg        <= 1'b0;
      res_data_reg   <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_reg + PW'(capture_fire);
      rd_ptr_reg     <= rd_ptr_next;
      tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(issue_fire);
      tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(capture_fire);
      count_reg      <= count_next;
      inflight_reg   <= inflight_next;
      err_reg        <= err_reg | stray_fire;
      res_data_reg   <= res_data_next;
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) occupancy <= DEPTH_W);

endmodule

// File: tb/tb_div_result_buffer.sv
// Scoreboard bench for div_result_buffer: directed scenarios plus randomized traffic against
// a queue-based reference of reserved slots, pending tags and queued results.
module tb_div_result_buffer;

  localparam int N_BITS = 32;
  localparam int DEPTH  = 4;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic                       issue_valid_i = 1'b0;
  logic                       issue_rem_i = 1'b0;
  logic                       issue_ready_o;
  logic                       div_valid_i = 1'b0;
  logic [N_BITS-1:0]          div_q_i = '0;
  logic [N_BITS-1:0]          div_r_i = '0;
  logic                       res_valid_o;
  logic [N_BITS-1:0]          res_data_o;
  logic                       res_ready_i = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic                       err_o;

  div_result_buffer #(.N_BITS(N_BITS), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_rem_i   (issue_rem_i),
    .issue_ready_o (issue_ready_o),
    .div_valid_i   (div_valid_i),
    .div_q_i       (div_q_i),
    .div_r_i       (div_r_i),
    .res_valid_o   (res_valid_o),
    .res_data_o    (res_data_o),
    .res_ready_i   (res_ready_i),
    .count_o       (count_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: tags of ops in flight, results awaiting the consumer, sticky error.
  logic              tag_q [$];
  logic [N_BITS-1:0] exp_q [$];
  logic              m_err = 1'b0;
  int                n_tests = 0;
  int                n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: head must match the oldest expected result; a handshake retires it.
  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected no result at %0t", res_data_o, $time);
      end else begin
        chk("res_data", res_data_o, exp_q[0]);
        $display("[TB] head %h ready=%0d", res_data_o, res_ready_i);
        if (res_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic step(input logic iv, input logic rem, input logic dv,
                      input logic [31:0] q, input logic [31:0] r, input logic rr);
    int   occ;
    logic t;
    occ = exp_q.size() + tag_q.size();
    chk("count", 32'(count_o), 32'(exp_q.size()));
    chk("res_valid", 32'(res_valid_o), 32'(exp_q.size() != 0));
    chk("issue_ready", 32'(issue_ready_o), 32'(occ < DEPTH));
    chk("err", 32'(err_o), 32'(m_err));
    issue_valid_i = iv;
    issue_rem_i   = rem;
    div_valid_i   = dv;
    div_q_i       = q;
    div_r_i       = r;
    res_ready_i   = rr;
    if (dv) begin
      if (tag_q.size() != 0) begin
        t = tag_q.pop_front();
        exp_q.push_back(t ? r : q);
      end else begin
        m_err = 1'b1;
      end
    end
    if (iv && occ < DEPTH) tag_q.push_back(rem);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    issue_valid_i = 1'b0;
    div_valid_i = 1'b0;
    res_ready_i = 1'b0;
    tag_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("reset_data", res_data_o, 32'h0);
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    do_reset();

    // Idle after reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // Single quotient op, then pop; head holds its last value when empty
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFD, 32'h1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("hold_last", res_data_o, 32'hFFFF_FFFD);

    // Four ops with tags 1,0,1,0 -> drain order 20,11,22,13
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(10 + i), 32'(20 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);

    // Full FIFO: drain and issue together -> issue refused, credit next cycle
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(100 + i), 32'(200 + i), 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h55, 32'hAA, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);

    // Stray result with nothing in flight
    step(0, 0, 1, 32'hDEAD_BEEF, 32'h1234, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);

    // Ops in flight are forgotten by reset; late completion is stray
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 1, 32'h7, 32'h8, 0);
    step(0, 0, 0, 0, 0, 0);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4), $urandom, $urandom,
           1'($urandom_range(0, 9) < 5));
    end

    // Complete and drain everything outstanding
    for (int i = 0; i < 12; i++) step(0, 0, (tag_q.size() != 0), $urandom, $urandom, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
